dmem_arbiter: RTL and testbench

- Controller and arbiter in front of the single-port synchronous data memory. Memory side: 1-cycle registered read, word index = addr[11:2].
- Shares the memory between two requesters: port 0 = core load/store, port 1 = DMA/debug.
- Sequences byte and halfword stores as read-modify-write. Aligns and extends sub-word loads. Flags misaligned and out-of-range accesses without touching memory.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_lane_align.sv | 48 ++++
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - access size encodings carried on rX_size
//   - controller state enum
//   - latched transaction record
//   - default memory depth in words
package dmem_pkg;

    localparam int MEM_WORDS_DEFAULT = 1024;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        DONE
    } state_e;

    // Everything the controller needs to remember about the accepted request.
    typedef struct packed {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        size_e       size;
        logic        uns;
    } xact_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory.
//   old_word    in  32  word read from memory
//   new_data    in  32  right-justified store data
//   byte_off    in  2   byte offset of the access within the word
//   size        in  2   access size (byte / half / word)
//   uns         in  1   zero-extend (1) or sign-extend (0) loads
//   load_data   out 32  selected lane shifted to bit 0 and extended
//   merged_word out 32  old_word with the addressed lane replaced by new_data
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  byte_off,
    input  size_e       size,
    input  logic        uns,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [31:0] shifted;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a latch behind.
    always_comb begin
        shifted     = old_word >> {byte_off, 3'b000};
        load_data   = old_word;
        merged_word = new_data;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
                merged_word = old_word;
                merged_word[{byte_off, 3'b000} +: 8] = new_data[7:0];
            end
            SZ_HALF: begin
                // Half accesses are 2-byte aligned, so only byte_off[1] picks the lane.
                load_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
                merged_word = old_word;
                merged_word[{byte_off[1], 4'b0000} +: 16] = new_data[15:0];
            end
            default: begin
                load_data   = old_word;
                merged_word = new_data;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port controller in front of a single-port synchronous data
// memory (1-cycle registered read, word index = addr[11:2]).
//   Port 0 = core load/store, port 1 = DMA/debug. Round-robin or fixed priority.
//   Sub-word stores run as read-modify-write; sub-word loads are aligned and
//   extended; misaligned, out-of-range and illegal-size accesses complete with
//   err and never touch memory.
// Ports (X in {0,1}):
//   clk, rst_n                     clock, synchronous active-low reset
//   rX_req/we/addr/wdata/size/uns  request side, held until granted
//   rX_gnt                         accept strobe (combinational, IDLE only)
//   rX_done/err/rdata              one-cycle completion, error flag, load data
//   mem_read/write/addr/wdata      memory command, driven from registered state
//   mem_rdata                      registered memory read data
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [1:0]  r0_size,
    input  logic        r0_uns,
    output logic        r0_gnt,
    output logic        r0_done,
    output logic        r0_err,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [1:0]  r1_size,
    input  logic        r1_uns,
    output logic        r1_gnt,
    output logic        r1_done,
    output logic        r1_err,
    output logic [31:0] r1_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    state_e      state;
    xact_t       cur;
    logic        prio;          // 1 = port 1 wins the next tie
    logic [1:0]  done_q;
    logic        err_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        pick1;
    logic        accept;
    logic        bad;
    xact_t       req_x;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    always_comb begin
        pick1  = r1_req && (!r0_req || (FIXED_PRIO == 0 && prio));
        accept = (state == IDLE) && (r0_req || r1_req);

        req_x.owner = pick1;
        req_x.we    = pick1 ? r1_we    : r0_we;
        req_x.addr  = pick1 ? r1_addr  : r0_addr;
        req_x.wdata = pick1 ? r1_wdata : r0_wdata;
        req_x.size  = size_e'(pick1 ? r1_size : r0_size);
        req_x.uns   = pick1 ? r1_uns   : r0_uns;

        bad = (req_x.size == SZ_BAD)
            || (req_x.size == SZ_HALF && req_x.addr[0])
            || (req_x.size == SZ_WORD && req_x.addr[1:0] != 2'b00)
            || ({1'b0, req_x.addr} >= ADDR_LIMIT);
    end

    // NOTE: the strobes are qualified with rst_n so a reset asserted mid-RMW
    // stops the pending write at that very edge instead of one cycle later.
    assign r0_gnt    = rst_n && accept && !pick1;
    assign r1_gnt    = rst_n && accept &&  pick1;
    assign mem_read  = rst_n && mem_read_q;
    assign mem_write = rst_n && mem_write_q;
    assign mem_addr  = mem_addr_q;
    // In MERGE the old word has just arrived, so the write data is built from it.
    assign mem_wdata = (state == MERGE) ? merged_word : mem_wdata_q;

    assign r0_done  = done_q[0];
    assign r1_done  = done_q[1];
    assign r0_err   = done_q[0] && err_q;
    assign r1_err   = done_q[1] && err_q;
    assign r0_rdata = (done_q[0] && !err_q && !cur.we) ? load_data : 32'd0;
    assign r1_rdata = (done_q[1] && !err_q && !cur.we) ? load_data : 32'd0;

    dmem_lane_align u_align (
        .old_word    (mem_rdata),
        .new_data    (cur.wdata),
        .byte_off    (cur.addr[1:0]),
        .size        (cur.size),
        .uns         (cur.uns),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // NOTE: state is updated only with non-blocking assignments; the reset
    // branch is sampled on the clock edge (synchronous reset).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur         <= '0;
            prio        <= 1'b0;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            done_q <= 2'b00;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur  <= req_x;
                        prio <= ~req_x.owner;
                        if (bad) begin
                            state                <= DONE;
                            done_q[req_x.owner]  <= 1'b1;
                            err_q                <= 1'b1;
                        end else begin
                            state       <= ACCESS;
                            mem_addr_q  <= req_x.addr;
                            mem_wdata_q <= req_x.wdata;
                            mem_read_q  <= !req_x.we || (req_x.size != SZ_WORD);
                            mem_write_q <= req_x.we && (req_x.size == SZ_WORD);
                        end
                    end
                end
                ACCESS: begin
                    mem_read_q <= 1'b0;
                    if (cur.we && cur.size != SZ_WORD) begin
                        state       <= MERGE;
                        mem_write_q <= 1'b1;
                    end else begin
                        state             <= DONE;
                        mem_write_q       <= 1'b0;
                        done_q[cur.owner] <= 1'b1;
                    end
                end
                MERGE: begin
                    state             <= DONE;
                    mem_write_q       <= 1'b0;
                    done_q[cur.owner] <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a transaction-level
// reference model checked every cycle, plus literal expectations per test.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int MW = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [1:0]       req = '0, we = '0, uns = '0;
    logic [1:0][31:0] addr = '0, wdata = '0;
    logic [1:0][1:0]  size = '0;

    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic        b_gnt0, b_gnt1, b_done0, b_done1, b_err0, b_err1;
    logic [31:0] b_rdata0, b_rdata1;
    logic        b_mem_read, b_mem_write;
    logic [31:0] b_mem_addr, b_mem_wdata;

    logic [31:0] mem_arr [MW];
    logic [31:0] ref_mem [MW];
    logic [31:0] last_wr = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.MEM_WORDS(MW), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
        .r0_size(size[0]), .r0_uns(uns[0]),
        .r0_gnt(gnt0), .r0_done(done0), .r0_err(err0), .r0_rdata(rdata0),
        .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
        .r1_size(size[1]), .r1_uns(uns[1]),
        .r1_gnt(gnt1), .r1_done(done1), .r1_err(err1), .r1_rdata(rdata1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Fixed-priority instance sharing the request inputs; only its grants matter.
    dmem_arbiter #(.MEM_WORDS(MW), .FIXED_PRIO(1)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
        .r0_size(size[0]), .r0_uns(uns[0]),
        .r0_gnt(b_gnt0), .r0_done(b_done0), .r0_err(b_err0), .r0_rdata(b_rdata0),
        .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
        .r1_size(size[1]), .r1_uns(uns[1]),
        .r1_gnt(b_gnt1), .r1_done(b_done1), .r1_err(b_err1), .r1_rdata(b_rdata1),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(32'd0)
    );

    // Single-port memory with a 1-cycle registered read.
    always @(posedge clk) begin
        if (mem_read)  mem_rdata <= mem_arr[mem_addr[11:2]];
        if (mem_write) mem_arr[mem_addr[11:2]] <= mem_wdata;
    end

    always @(negedge clk) if (mem_write) last_wr = mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (spec-level arithmetic) ----------------
    function automatic logic [31:0] lane_mask(input logic [1:0] s);
        if (s == 2'b00) return 32'h0000_00FF;
        if (s == 2'b01) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] merge_value(input logic [31:0] old, input logic [31:0] nd,
                                                input logic [31:0] a, input logic [1:0] s);
        int sh = int'(a[1:0]) * 8;
        logic [31:0] m = lane_mask(s) << sh;
        return (old & ~m) | ((nd << sh) & m);
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] s, input logic u);
        int sh = int'(a[1:0]) * 8;
        logic [31:0] m = lane_mask(s);
        logic [31:0] top = m & ~(m >> 1);
        logic [31:0] v = (w >> sh) & m;
        if (!u && (v & top) != 0) v = v | ~m;
        return v;
    endfunction

    function automatic logic is_err(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00)
            || (a >= 32'(MW * 4));
    endfunction

    logic        pending = 1'b0;
    logic        favour = 1'b0;
    int          p_port, p_gcyc, p_dcyc;
    logic        p_we, p_uns, p_err;
    logic [31:0] p_addr, p_wdata;
    logic [1:0]  p_size;

    always @(negedge clk) begin : compare_proc
        logic [1:0]  eg, ed, ee;
        logic [31:0] erd0, erd1, ewd;
        logic        e_rd, e_wr, sub;
        if (!rst_n) begin
            check("gnt_in_reset", {30'd0, gnt1, gnt0}, 32'd0);
            check("strobe_in_reset", {30'd0, mem_read, mem_write}, 32'd0);
            pending = 1'b0;
            favour  = 1'b0;
        end else begin
            eg = 2'b00;
            if (!pending) begin
                if (req == 2'b11) eg[favour] = 1'b1;
                else eg = req;
            end
            check("gnt", {30'd0, gnt1, gnt0}, {30'd0, eg});

            ed = 2'b00; ee = 2'b00; erd0 = '0; erd1 = '0;
            e_rd = 1'b0; e_wr = 1'b0; ewd = '0;
            sub = p_we && p_size != 2'b10;
            if (pending && cyc == p_dcyc) begin
                ed[p_port] = 1'b1;
                ee[p_port] = p_err;
                if (!p_we && !p_err) begin
                    if (p_port == 0) erd0 = load_value(ref_mem[p_addr[11:2]], p_addr, p_size, p_uns);
                    else             erd1 = load_value(ref_mem[p_addr[11:2]], p_addr, p_size, p_uns);
                end
            end
            check("done", {30'd0, done1, done0}, {30'd0, ed});
            check("err", {30'd0, err1, err0}, {30'd0, ee});
            check("rdata0", rdata0, erd0);
            check("rdata1", rdata1, erd1);

            if (pending && !p_err) begin
                if (cyc == p_gcyc + 1) begin
                    e_rd = !p_we || sub;
                    e_wr = p_we && !sub;
                    ewd  = p_wdata;
                end else if (cyc == p_gcyc + 2 && sub) begin
                    e_wr = 1'b1;
                    ewd  = merge_value(ref_mem[p_addr[11:2]], p_wdata, p_addr, p_size);
                end
            end
            check("mem_strobes", {30'd0, mem_read, mem_write}, {30'd0, e_rd, e_wr});
            if (e_rd || e_wr) check("mem_addr", mem_addr, p_addr);
            if (e_wr) check("mem_wdata", mem_wdata, ewd);

            if (pending && cyc == p_dcyc) begin
                if (p_we && !p_err)
                    ref_mem[p_addr[11:2]] = merge_value(ref_mem[p_addr[11:2]], p_wdata, p_addr, p_size);
                pending = 1'b0;
            end
            if (eg != 2'b00) begin
                p_port  = eg[1] ? 1 : 0;
                p_we    = we[p_port];
                p_addr  = addr[p_port];
                p_wdata = wdata[p_port];
                p_size  = size[p_port];
                p_uns   = uns[p_port];
                p_err   = is_err(p_addr, p_size);
                p_gcyc  = cyc;
                p_dcyc  = cyc + (p_err ? 1 : ((p_we && p_size != 2'b10) ? 3 : 2));
                favour  = ~eg[1];
                pending = 1'b1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic u,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic seen;
        int   g;
        @(posedge clk); #1;
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; size[p] = s; uns[p] = u;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = (p == 0) ? gnt0 : gnt1;
        end
        check("txn_gnt", {31'd0, seen}, 32'd1);
        g = cyc;
        @(posedge clk); #1;
        req[p] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = (p == 0) ? done0 : done1;
        end
        check("txn_done", {31'd0, seen}, 32'd1);
        check("txn_latency", cyc - g, exp_lat);
        check("txn_rdata", (p == 0) ? rdata0 : rdata1, exp_rd);
        check("txn_err", {31'd0, (p == 0) ? err0 : err1}, {31'd0, exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rr_exp [4];
        logic       seen;
        logic       p1_act;
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < MW; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {24'd0, gnt0, gnt1, done0, done1, err0, err1, mem_read, mem_write}, 32'd0);
        check("reset_rdata", rdata0 | rdata1, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Both ports request continuously: round-robin alternates, fixed keeps port 0.
        we = 2'b00; size[0] = 2'b10; size[1] = 2'b10; addr[0] = 32'h10; addr[1] = 32'h20;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                seen = gnt0 | gnt1;
            end
            check("rr_order", {30'd0, gnt1, gnt0}, {30'd0, rr_exp[k]});
            check("fixed_prio_gnt", {30'd0, b_gnt1, b_gnt0}, 32'd1);
        end
        @(posedge clk); #1;
        req = 2'b00;
        repeat (5) @(posedge clk);

        // Word store then word load.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 2);
        txn(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 2);

        // Read-modify-write byte store from port 1, then sub-word loads.
        txn(0, 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 32'h0, 1'b0, 2);
        txn(1, 1'b1, 32'h21, 32'h000000AA, 2'b00, 1'b0, 32'h0, 1'b0, 3);
        check("merge_word", last_wr, 32'h1122AA44);
        txn(0, 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 32'hFFFFFFAA, 1'b0, 2);
        txn(1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b1, 32'h00001122, 1'b0, 2);
        txn(0, 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 32'h00001122, 1'b0, 2);

        // Errors: misaligned half, out-of-range word store, illegal size, out-of-range byte.
        txn(0, 1'b0, 32'h13, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1);
        txn(1, 1'b1, 32'h1002, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b1, 1);
        txn(0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1);
        txn(1, 1'b0, 32'h1000, 32'h0, 2'b00, 1'b1, 32'h0, 1'b1, 1);
        // Last valid byte and word.
        txn(1, 1'b1, 32'hFFF, 32'h0000005A, 2'b00, 1'b0, 32'h0, 1'b0, 3);
        txn(0, 1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, 32'h5A000000, 1'b0, 2);

        // Reset during MERGE of a byte store aborts it.
        txn(0, 1'b1, 32'h30, 32'h55667788, 2'b10, 1'b0, 32'h0, 1'b0, 2);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h31; wdata[0] = 32'h99; size[0] = 2'b00;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = gnt0;
        end
        check("abort_gnt", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;                 // now in ACCESS
        @(posedge clk); #1;
        rst_n = 1'b0;                  // now in MERGE
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_flags", {24'd0, gnt0, gnt1, done0, done1, err0, err1, mem_read, mem_write}, 32'd0);
        check("abort_rdata", rdata0 | rdata1, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            seen = seen | done0 | done1;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);
        txn(0, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 32'h55667788, 1'b0, 2);

        // Port 1 request held during a port 0 transaction, dropped before its grant.
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; size[0] = 2'b10;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = gnt0;
        end
        check("drop_p0_gnt", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20; size[1] = 2'b10;
        @(posedge clk); #1;
        req[1] = 1'b0;
        seen = 1'b0; p1_act = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done0) begin
                seen = 1'b1;
                check("drop_p0_rdata", rdata0, 32'hDEADBEEF);
            end
            p1_act = p1_act | gnt1 | done1;
        end
        check("drop_p0_done", {31'd0, seen}, 32'd1);
        check("drop_p1_quiet", {31'd0, p1_act}, 32'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
